change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vend_pkg.sv | 53 +++++
 rtl/change_dispenser.sv | 158 +++++++++++++++
 tb/tb_change_dispenser.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encoding, coin values, greedy coin
// selection and the change dispenser state encoding.
package vend_pkg;

    // Coin denomination encoding, shared by coin inputs and the dispenser output
    typedef enum logic [1:0] {
        NONE = 2'b00,
        C5   = 2'b01,
        C10  = 2'b10,
        C20  = 2'b11
    } coin_t;

    localparam logic [7:0] C5_VALUE  = 8'd5;
    localparam logic [7:0] C10_VALUE = 8'd10;
    localparam logic [7:0] C20_VALUE = 8'd20;

    // Change dispenser controller states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        ISSUE  = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } disp_state_t;

    // Face value of a coin; NONE is worth nothing
    function automatic logic [7:0] coin_value(input coin_t coin);
        logic [7:0] value;
        case (coin)
            C5:      value = C5_VALUE;
            C10:     value = C10_VALUE;
            C20:     value = C20_VALUE;
            default: value = 8'd0;
        endcase
        return value;
    endfunction

    // Largest coin not exceeding the amount still owed; NONE when below 5
    function automatic coin_t greedy_coin(input logic [7:0] amount);
        coin_t coin;
        if (amount >= C20_VALUE) begin
            coin = C20;
        end else if (amount >= C10_VALUE) begin
            coin = C10;
        end else if (amount >= C5_VALUE) begin
            coin = C5;
        end else begin
            coin = NONE;
        end
        return coin;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested amount with the fewest 5/10/20
// coins, one coin per hopper handshake. All outputs are registered.
// Optional feature macro HOPPER_TIMEOUT_EN: abort a coin whose hopper
// acknowledge does not arrive within TIMEOUT_CYCLES cycles.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [7:0] req_amount,
    output logic       req_ready,
    output logic       coin_valid,
    output logic [1:0] coin_out,
    input  logic       coin_ack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] remaining
);

    // The counter is 8 bits wide, so the limit must stay in 1..255.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    disp_state_t state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        coin_valid_q, coin_valid_d;
    coin_t       coin_out_q, coin_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [7:0]  remaining_q, remaining_d;
    coin_t       sel_coin_s;

`ifdef HOPPER_TIMEOUT_EN
    // Last counter value before giving up; the coin is held TIMEOUT_CYCLES cycles.
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Next-state logic plus next values of every registered output
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        error_d     = error_q;
        coin_out_d  = NONE;
        sel_coin_s  = greedy_coin(remaining_q);
`ifdef HOPPER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    remaining_d = req_amount;
                    error_d     = 1'b0;
                    state_d     = SELECT;
                end else begin
                    state_d     = IDLE;
                end
            end
            SELECT: begin
`ifdef HOPPER_TIMEOUT_EN
                tmo_cnt_d = 8'd0;
`endif
                if (sel_coin_s == NONE) begin
                    // Anything left below 5 cannot be paid out.
                    error_d = error_q | (remaining_q != 8'd0);
                    state_d = DONE;
                end else begin
                    coin_out_d = sel_coin_s;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (coin_ack) begin
                    // Greedy choice never exceeds remaining, so no underflow.
                    remaining_d = remaining_q - coin_value(coin_out_q);
                    state_d     = GAP;
                end else begin
`ifdef HOPPER_TIMEOUT_EN
                    if (tmo_cnt_q == TMO_LIMIT) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        tmo_cnt_d  = tmo_cnt_q + 8'd1;
                        coin_out_d = coin_out_q;
                        state_d    = ISSUE;
                    end
`else
                    coin_out_d = coin_out_q;
                    state_d    = ISSUE;
`endif
                end
            end
            GAP: begin
                state_d = SELECT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        coin_valid_d = (state_d == ISSUE);
        done_d       = (state_d == DONE);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            coin_valid_q <= 1'b0;
            coin_out_q   <= NONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            remaining_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            coin_valid_q <= coin_valid_d;
            coin_out_q   <= coin_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            remaining_q  <= remaining_d;
        end
    end

`ifdef HOPPER_TIMEOUT_EN
    // Hopper acknowledge wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign req_ready  = req_ready_q;
    assign coin_valid = coin_valid_q;
    assign coin_out   = coin_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign remaining  = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Table-driven bench for change_dispenser, plus hand-written sequences for
// reset during a coin handshake and the hopper acknowledge timeout.
// Cycle 0 is the cycle in which the request is presented.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [7:0] req_amount;
    logic       req_ready;
    logic       coin_valid;
    logic [1:0] coin_out;
    logic       coin_ack;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] remaining;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  amt;
        int          dly;      // ISSUE cycles before the hopper acks
        bit          stray;    // drive req_valid and coin_ack while busy outside ISSUE
        logic [15:0] coins;    // coin i at bits [2i+1:2i]
        int          ncoins;
        logic [7:0]  rem;
        logic        err;
        int          done_lat;
    } vec_t;

    vec_t vecs[9];

    change_dispenser #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .coin_valid (coin_valid),
        .coin_out   (coin_out),
        .coin_ack   (coin_ack),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Presents one request and plays the hopper until done or the budget expires.
    task automatic run_req(input logic [7:0] amt, input int dly, input bit stray,
                           output logic [15:0] coins, output int ncoins,
                           output int first_lat, output int done_lat,
                           output logic [7:0] rem, output logic err);
        int  waited;
        bit  fin;
        coins = 16'd0; ncoins = 0; first_lat = -1; done_lat = -1;
        rem = 8'd0; err = 1'b0; waited = 0; fin = 1'b0;
        req_valid = 1'b1; req_amount = amt; coin_ack = 1'b0;
        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            coin_ack  = 1'b0;
            if (done) begin
                done_lat = cyc; rem = remaining; err = error; fin = 1'b1;
            end else if (coin_valid) begin
                if (first_lat < 0) first_lat = cyc;
                if (waited >= dly) begin
                    if (ncoins < 8) coins[2*ncoins +: 2] = coin_out;
                    ncoins++;
                    coin_ack = 1'b1;
                    waited   = 0;
                end else begin
                    waited++;
                end
            end else if (stray && busy) begin
                coin_ack   = 1'b1;
                req_valid  = 1'b1;
                req_amount = 8'd200;
            end
        end
        req_valid = 1'b0;
        coin_ack  = 1'b0;
    endtask

    task automatic apply_vec(input int i);
        logic [15:0] coins;
        int          ncoins, first_lat, done_lat;
        logic [7:0]  rem;
        logic        err;
        string       tag;
        tag = $sformatf("v%0d_amt%0d", i, vecs[i].amt);
        check({tag, "_ready_before"}, 32'(req_ready), 32'd1);
        run_req(vecs[i].amt, vecs[i].dly, vecs[i].stray, coins, ncoins, first_lat, done_lat, rem, err);
        check({tag, "_ncoins"}, 32'(ncoins), 32'(vecs[i].ncoins));
        check({tag, "_coins"}, 32'(coins), 32'(vecs[i].coins));
        check({tag, "_first_coin_lat"}, 32'(first_lat), (vecs[i].ncoins > 0) ? 32'd2 : 32'hFFFF_FFFF);
        check({tag, "_done_lat"}, 32'(done_lat), 32'(vecs[i].done_lat));
        check({tag, "_remaining"}, 32'(rem), 32'(vecs[i].rem));
        check({tag, "_error"}, 32'(err), 32'(vecs[i].err));
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_error_sticky"}, 32'(error), 32'(vecs[i].err));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_coin_valid"}, 32'(coin_valid), 32'd0);
        check({tag, "_coin_out"}, 32'(coin_out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_remaining"}, 32'(remaining), 32'd0);
    endtask

    initial begin
        int hi, dl, wt;
        logic [7:0] rem_seen;
        logic       err_seen;

        //          amt    dly stray coins                                                     n  rem  err done
        vecs[0] = '{8'd35, 1, 1'b0, {10'b0, 2'b01, 2'b10, 2'b11},                             3, 8'd0, 1'b0, 14};
        vecs[1] = '{8'd0,  0, 1'b0, 16'b0,                                                    0, 8'd0, 1'b0, 2};
        vecs[2] = '{8'd17, 0, 1'b0, {12'b0, 2'b01, 2'b10},                                    2, 8'd2, 1'b1, 8};
        vecs[3] = '{8'd40, 0, 1'b0, {12'b0, 2'b11, 2'b11},                                    2, 8'd0, 1'b0, 8};
        vecs[4] = '{8'd5,  2, 1'b0, {14'b0, 2'b01},                                           1, 8'd0, 1'b0, 7};
        vecs[5] = '{8'd95, 0, 1'b0, {4'b0, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11},         6, 8'd0, 1'b0, 20};
        vecs[6] = '{8'd4,  0, 1'b0, 16'b0,                                                    0, 8'd4, 1'b1, 2};
        vecs[7] = '{8'd25, 0, 1'b1, {12'b0, 2'b01, 2'b11},                                    2, 8'd0, 1'b0, 8};
        vecs[8] = '{8'd10, 0, 1'b0, {14'b0, 2'b10},                                           1, 8'd0, 1'b0, 5};

        rst_n = 1'b0; req_valid = 1'b0; req_amount = 8'd0; coin_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        check("reset_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) apply_vec(i);

        // Reset while a coin is on offer: everything clears without a clock edge.
        req_valid = 1'b1; req_amount = 8'd20;
        @(negedge clk);
        req_valid = 1'b0;
        wt = 0;
        while (!coin_valid && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        check("rst_mid_reached_issue", 32'(coin_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid_async");
        check("rst_mid_async_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(req_ready), 32'd1);
        check("rst_release_done", 32'(done), 32'd0);
        check("rst_release_busy", 32'(busy), 32'd0);
        apply_vec(8);

        // Hopper never acknowledges a 20.
        req_valid = 1'b1; req_amount = 8'd20; coin_ack = 1'b0;
        hi = 0; dl = -1; rem_seen = 8'd0; err_seen = 1'b0;
        for (int cyc = 1; cyc <= 130; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (coin_valid) hi++;
            if (done && dl < 0) begin
                dl = cyc; rem_seen = remaining; err_seen = error;
            end
        end
`ifdef HOPPER_TIMEOUT_EN
        check("tmo_valid_cycles", 32'(hi), 32'd8);
        check("tmo_done_lat", 32'(dl), 32'd10);
        check("tmo_remaining", 32'(rem_seen), 32'd20);
        check("tmo_error", 32'(err_seen), 32'd1);
        check("tmo_error_sticky", 32'(error), 32'd1);
        check("tmo_coin_valid_low", 32'(coin_valid), 32'd0);
`else
        check("notmo_valid_held", 32'(hi >= 100), 32'd1);
        check("notmo_no_done", 32'(dl), 32'hFFFF_FFFF);
        check("notmo_still_valid", 32'(coin_valid), 32'd1);
        check("notmo_coin_20", 32'(coin_out), 32'd3);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("final_reset");
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
